// File: rtl/decode_execute_slice.sv
// decode_execute_slice
//   Datapath slice of a five-stage RV32I pipeline: ID-stage decode (control
//   decoder, 32-entry register file, immediate extender), EX-stage
//   combinational logic (forwarding muxes, ALU, branch compare, branch target)
//   and the EX/MEM pipeline register. The ID/EX register lives outside.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   Defined   -> register reads see a same-cycle write (write-through).
//   Undefined -> register reads return the stored value until the next edge.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   instrD                instruction in ID
//   regWriteW/rdW/resultW write-back port (resultW is also forward source 01)
//   *D outputs            decoded controls, register reads, fields, immediate
//   *E inputs             EX operands and controls from the ID/EX register
//   forwardAE/forwardBE   00 register, 01 resultW, 10 aluResultM
//   aluResultE, writeDataE, branchTargetE, branchTakenE  EX results
//   stallM, flushM        EX/MEM hold and clear (flush wins)
//   *M outputs            EX/MEM register contents
module decode_execute_slice #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    // Decode
    input  logic [31:0]               instrD,
    input  logic                      regWriteW,
    input  logic [REG_ADDR_WIDTH-1:0] rdW,
    input  logic [DATA_WIDTH-1:0]     resultW,
    output logic                      regWriteD,
    output logic                      memWriteD,
    output logic                      memReadD,
    output logic                      branchD,
    output logic                      jumpD,
    output logic                      jalrD,
    output logic                      aluSrcD,
    output logic [1:0]                resultSrcD,
    output logic [3:0]                aluControlD,
    output logic [2:0]                addressingModeD,
    output logic [DATA_WIDTH-1:0]     rd1D,
    output logic [DATA_WIDTH-1:0]     rd2D,
    output logic [REG_ADDR_WIDTH-1:0] rs1D,
    output logic [REG_ADDR_WIDTH-1:0] rs2D,
    output logic [REG_ADDR_WIDTH-1:0] rdD,
    output logic [DATA_WIDTH-1:0]     extImmD,
    // Execute
    input  logic [DATA_WIDTH-1:0]     pcE,
    input  logic [DATA_WIDTH-1:0]     rd1E,
    input  logic [DATA_WIDTH-1:0]     rd2E,
    input  logic [DATA_WIDTH-1:0]     extImmE,
    input  logic [DATA_WIDTH-1:0]     pcPlus4E,
    input  logic [REG_ADDR_WIDTH-1:0] rdE,
    input  logic                      aluSrcE,
    input  logic                      branchE,
    input  logic                      regWriteE,
    input  logic                      memWriteE,
    input  logic [3:0]                aluControlE,
    input  logic [1:0]                resultSrcE,
    input  logic [2:0]                addressingModeE,
    input  logic [1:0]                forwardAE,
    input  logic [1:0]                forwardBE,
    output logic [DATA_WIDTH-1:0]     aluResultE,
    output logic [DATA_WIDTH-1:0]     writeDataE,
    output logic [DATA_WIDTH-1:0]     branchTargetE,
    output logic                      branchTakenE,
    // EX/MEM
    input  logic                      stallM,
    input  logic                      flushM,
    output logic [DATA_WIDTH-1:0]     aluResultM,
    output logic [DATA_WIDTH-1:0]     writeDataM,
    output logic [DATA_WIDTH-1:0]     pcPlus4M,
    output logic [REG_ADDR_WIDTH-1:0] rdM,
    output logic                      regWriteM,
    output logic                      memWriteM,
    output logic [1:0]                resultSrcM,
    output logic [2:0]                addressingModeM
);

    localparam int NumRegs = 2 ** REG_ADDR_WIDTH;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;

    localparam logic [3:0] AluAdd   = 4'b0000;
    localparam logic [3:0] AluSub   = 4'b0001;
    localparam logic [3:0] AluAnd   = 4'b0010;
    localparam logic [3:0] AluOr    = 4'b0011;
    localparam logic [3:0] AluXor   = 4'b0100;
    localparam logic [3:0] AluSll   = 4'b0101;
    localparam logic [3:0] AluSrl   = 4'b0110;
    localparam logic [3:0] AluSra   = 4'b0111;
    localparam logic [3:0] AluSlt   = 4'b1000;
    localparam logic [3:0] AluSltu  = 4'b1001;
    localparam logic [3:0] AluPassB = 4'b1010;
    localparam logic [3:0] AluBne   = 4'b1011;
    localparam logic [3:0] AluBge   = 4'b1100;
    localparam logic [3:0] AluBgeu  = 4'b1101;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;

    assign opcode   = instrD[6:0];
    assign funct3   = instrD[14:12];
    assign funct7b5 = instrD[30];
    assign rs1D     = instrD[19:15];
    assign rs2D     = instrD[24:20];
    assign rdD      = instrD[11:7];

    // funct7[5] picks SUB only for register-register ops; for shifts it
    // picks SRA in both R and I forms.
    function automatic logic [3:0] aluOpFn(input logic [2:0] f3, input logic f7b5,
                                           input logic isReg);
        logic [3:0] op;
        unique case (f3)
            3'b000:  op = (isReg && f7b5) ? AluSub : AluAdd;
            3'b001:  op = AluSll;
            3'b010:  op = AluSlt;
            3'b011:  op = AluSltu;
            3'b100:  op = AluXor;
            3'b101:  op = f7b5 ? AluSra : AluSrl;
            3'b110:  op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

    function automatic logic [3:0] branchOpFn(input logic [2:0] f3);
        logic [3:0] op;
        case (f3)
            3'b000:  op = AluSub;   // BEQ
            3'b001:  op = AluBne;
            3'b100:  op = AluSlt;   // BLT
            3'b101:  op = AluBge;
            3'b110:  op = AluSltu;  // BLTU
            3'b111:  op = AluBgeu;
            default: op = AluAdd;   // reserved: never taken
        endcase
        return op;
    endfunction

    always_comb begin
        regWriteD       = 1'b0;
        memWriteD       = 1'b0;
        memReadD        = 1'b0;
        branchD         = 1'b0;
        jumpD           = 1'b0;
        jalrD           = 1'b0;
        aluSrcD         = 1'b0;
        resultSrcD      = 2'b00;
        aluControlD     = AluAdd;
        addressingModeD = 3'b000;
        case (opcode)
            OpR: begin
                regWriteD   = 1'b1;
                aluControlD = aluOpFn(funct3, funct7b5, 1'b1);
            end
            OpI: begin
                regWriteD   = 1'b1;
                aluSrcD     = 1'b1;
                aluControlD = aluOpFn(funct3, funct7b5, 1'b0);
            end
            OpLoad: begin
                regWriteD       = 1'b1;
                memReadD        = 1'b1;
                resultSrcD      = 2'b01;
                aluSrcD         = 1'b1;
                addressingModeD = funct3;
            end
            OpStore: begin
                memWriteD       = 1'b1;
                aluSrcD         = 1'b1;
                addressingModeD = funct3;
            end
            OpBranch: begin
                branchD     = 1'b1;
                aluControlD = branchOpFn(funct3);
            end
            OpJal: begin
                regWriteD  = 1'b1;
                jumpD      = 1'b1;
                resultSrcD = 2'b10;
            end
            OpJalr: begin
                regWriteD  = 1'b1;
                jumpD      = 1'b1;
                jalrD      = 1'b1;
                aluSrcD    = 1'b1;
                resultSrcD = 2'b10;
            end
            OpLui: begin
                regWriteD   = 1'b1;
                aluSrcD     = 1'b1;
                aluControlD = AluPassB;
            end
            default: ;  // AUIPC, FENCE, SYSTEM and unknown: NOP
        endcase
    end

    logic [31:0] imm32;

    always_comb begin
        imm32 = {{20{instrD[31]}}, instrD[31:20]};  // I-format
        case (opcode)
            OpStore:  imm32 = {{20{instrD[31]}}, instrD[31:25], instrD[11:7]};
            OpBranch: imm32 = {{19{instrD[31]}}, instrD[31], instrD[7], instrD[30:25],
                               instrD[11:8], 1'b0};
            OpLui:    imm32 = {instrD[31:12], 12'b0};
            OpJal:    imm32 = {{11{instrD[31]}}, instrD[31], instrD[19:12], instrD[20],
                               instrD[30:21], 1'b0};
            default:  ;
        endcase
    end

    assign extImmD = DATA_WIDTH'($signed(imm32));

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] regs [NumRegs];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs[i] <= '0;
            end
        end else if (regWriteW && (rdW != '0)) begin
            regs[rdW] <= resultW;
        end
    end

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        rd1D = (rs1D == '0) ? '0 : regs[rs1D];
        rd2D = (rs2D == '0) ? '0 : regs[rs2D];
        if (regWriteW && (rdW != '0) && (rdW == rs1D)) rd1D = resultW;
        if (regWriteW && (rdW != '0) && (rdW == rs2D)) rd2D = resultW;
    end
`else
    always_comb begin
        rd1D = (rs1D == '0) ? '0 : regs[rs1D];
        rd2D = (rs2D == '0) ? '0 : regs[rs2D];
    end
`endif

    // ------------------------------------------------------------------
    // Execute
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] srcA;
    logic [DATA_WIDTH-1:0] srcB;
    logic [4:0]            shamt;

    always_comb begin
        case (forwardAE)
            2'b01:   srcA = resultW;
            2'b10:   srcA = aluResultM;
            default: srcA = rd1E;
        endcase
        case (forwardBE)
            2'b01:   writeDataE = resultW;
            2'b10:   writeDataE = aluResultM;
            default: writeDataE = rd2E;
        endcase
    end

    assign srcB          = aluSrcE ? extImmE : writeDataE;
    assign shamt         = srcB[4:0];
    assign branchTargetE = pcE + extImmE;

    always_comb begin
        aluResultE = '0;
        case (aluControlE)
            AluAdd:                aluResultE = srcA + srcB;
            AluSub, AluBne:        aluResultE = srcA - srcB;
            AluAnd:                aluResultE = srcA & srcB;
            AluOr:                 aluResultE = srcA | srcB;
            AluXor:                aluResultE = srcA ^ srcB;
            AluSll:                aluResultE = srcA << shamt;
            AluSrl:                aluResultE = srcA >> shamt;
            AluSra:                aluResultE = DATA_WIDTH'($signed(srcA) >>> shamt);
            AluSlt, AluBge:        aluResultE[0] = $signed(srcA) < $signed(srcB);
            AluSltu, AluBgeu:      aluResultE[0] = srcA < srcB;
            AluPassB:              aluResultE = srcB;
            default:               aluResultE = '0;
        endcase
    end

    logic condMet;

    always_comb begin
        condMet = 1'b0;
        case (aluControlE)
            AluSub:           condMet = (aluResultE == '0);
            AluBne:           condMet = (aluResultE != '0);
            AluSlt, AluSltu:  condMet = (aluResultE == DATA_WIDTH'(1));
            AluBge, AluBgeu:  condMet = (aluResultE == '0);
            default:          condMet = 1'b0;
        endcase
    end

    assign branchTakenE = branchE & condMet;

    // ------------------------------------------------------------------
    // EX/MEM register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aluResultM      <= '0;
            writeDataM      <= '0;
            pcPlus4M        <= '0;
            rdM             <= '0;
            regWriteM       <= 1'b0;
            memWriteM       <= 1'b0;
            resultSrcM      <= 2'b00;
            addressingModeM <= 3'b000;
        end else if (flushM) begin
            aluResultM      <= '0;
            writeDataM      <= '0;
            pcPlus4M        <= '0;
            rdM             <= '0;
            regWriteM       <= 1'b0;
            memWriteM       <= 1'b0;
            resultSrcM      <= 2'b00;
            addressingModeM <= 3'b000;
        end else if (!stallM) begin
            aluResultM      <= aluResultE;
            writeDataM      <= writeDataE;
            pcPlus4M        <= pcPlus4E;
            rdM             <= rdE;
            regWriteM       <= regWriteE;
            memWriteM       <= memWriteE;
            resultSrcM      <= resultSrcE;
            addressingModeM <= addressingModeE;
        end
    end

endmodule

// File: tb/tb_decode_execute_slice.sv
// tb_decode_execute_slice
//   Directed-vector bench for decode_execute_slice: decode, register file,
//   forwarding, ALU, branch and EX/MEM behaviour against hand-computed values.
module tb_decode_execute_slice;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instrD = '0;
    logic        regWriteW = 1'b0;
    logic [4:0]  rdW = '0;
    logic [31:0] resultW = '0;
    logic        regWriteD, memWriteD, memReadD, branchD, jumpD, jalrD, aluSrcD;
    logic [1:0]  resultSrcD;
    logic [3:0]  aluControlD;
    logic [2:0]  addressingModeD;
    logic [31:0] rd1D, rd2D, extImmD;
    logic [4:0]  rs1D, rs2D, rdD;
    logic [31:0] pcE = '0, rd1E = '0, rd2E = '0, extImmE = '0, pcPlus4E = '0;
    logic [4:0]  rdE = '0;
    logic        aluSrcE = 1'b0, branchE = 1'b0, regWriteE = 1'b0, memWriteE = 1'b0;
    logic [3:0]  aluControlE = '0;
    logic [1:0]  resultSrcE = '0;
    logic [2:0]  addressingModeE = '0;
    logic [1:0]  forwardAE = '0, forwardBE = '0;
    logic [31:0] aluResultE, writeDataE, branchTargetE;
    logic        branchTakenE;
    logic        stallM = 1'b0, flushM = 1'b0;
    logic [31:0] aluResultM, writeDataM, pcPlus4M;
    logic [4:0]  rdM;
    logic        regWriteM, memWriteM;
    logic [1:0]  resultSrcM;
    logic [2:0]  addressingModeM;

    int passCount  = 0;
    int checkCount = 0;

    decode_execute_slice dut (
        .clk(clk), .rst(rst),
        .instrD(instrD), .regWriteW(regWriteW), .rdW(rdW), .resultW(resultW),
        .regWriteD(regWriteD), .memWriteD(memWriteD), .memReadD(memReadD),
        .branchD(branchD), .jumpD(jumpD), .jalrD(jalrD), .aluSrcD(aluSrcD),
        .resultSrcD(resultSrcD), .aluControlD(aluControlD),
        .addressingModeD(addressingModeD), .rd1D(rd1D), .rd2D(rd2D),
        .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD), .extImmD(extImmD),
        .pcE(pcE), .rd1E(rd1E), .rd2E(rd2E), .extImmE(extImmE), .pcPlus4E(pcPlus4E),
        .rdE(rdE), .aluSrcE(aluSrcE), .branchE(branchE), .regWriteE(regWriteE),
        .memWriteE(memWriteE), .aluControlE(aluControlE), .resultSrcE(resultSrcE),
        .addressingModeE(addressingModeE), .forwardAE(forwardAE), .forwardBE(forwardBE),
        .aluResultE(aluResultE), .writeDataE(writeDataE), .branchTargetE(branchTargetE),
        .branchTakenE(branchTakenE), .stallM(stallM), .flushM(flushM),
        .aluResultM(aluResultM), .writeDataM(writeDataM), .pcPlus4M(pcPlus4M),
        .rdM(rdM), .regWriteM(regWriteM), .memWriteM(memWriteM),
        .resultSrcM(resultSrcM), .addressingModeM(addressingModeM)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            passCount++;
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } aluVec_t;

    aluVec_t aluVecs[14] = '{
        '{4'b0000, 32'd5,         32'd3,         32'd8},
        '{4'b0001, 32'd5,         32'd7,         32'hFFFF_FFFE},
        '{4'b0010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000},
        '{4'b0011, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0},
        '{4'b0100, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F},
        '{4'b0101, 32'd1,         32'h24,        32'h10},
        '{4'b0110, 32'h8000_0000, 32'd4,         32'h0800_0000},
        '{4'b0111, 32'h8000_0000, 32'd4,         32'hF800_0000},
        '{4'b1000, 32'hFFFF_FFFF, 32'd1,         32'd1},
        '{4'b1001, 32'hFFFF_FFFF, 32'd1,         32'd0},
        '{4'b1010, 32'd5,         32'hABCD,      32'hABCD},
        '{4'b1011, 32'd9,         32'd4,         32'd5},
        '{4'b1100, 32'd3,         32'd2,         32'd0},
        '{4'b1101, 32'd2,         32'd3,         32'd1}
    };

    typedef struct {
        string       tag;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        taken;
    } brVec_t;

    brVec_t brVecs[6] = '{
        '{"beqEq",      4'b0001, 32'd7,         32'd7,         1'b1},
        '{"bneEq",      4'b1011, 32'd7,         32'd7,         1'b0},
        '{"bltNeg",     4'b1000, 32'hFFFF_FFFF, 32'd1,         1'b1},
        '{"bgeuSmall",  4'b1101, 32'd1,         32'hFFFF_FFFF, 1'b0},
        '{"bgeEq",      4'b1100, 32'd5,         32'd5,         1'b1},
        '{"badCode",    4'b1110, 32'd5,         32'd5,         1'b0}
    };

    initial begin
        // Reset, checked before any clock edge.
        #1 rst = 1'b1;
        #1;
        checkVal("rstAluResultM", aluResultM, 32'd0);
        checkVal("rstRegWriteM", {31'd0, regWriteM}, 32'd0);
        #2 rst = 1'b0;

        // Decode: addi x1,x0,5
        instrD = 32'h0050_0093;
        #1;
        checkVal("addiRegWrite", {31'd0, regWriteD}, 32'd1);
        checkVal("addiAluSrc", {31'd0, aluSrcD}, 32'd1);
        checkVal("addiAluCtl", {28'd0, aluControlD}, 32'd0);
        checkVal("addiImm", extImmD, 32'd5);
        checkVal("addiRd", {27'd0, rdD}, 32'd1);
        // sw x2,8(x1)
        instrD = 32'h0020_A423;
        #1;
        checkVal("swMemWrite", {31'd0, memWriteD}, 32'd1);
        checkVal("swRegWrite", {31'd0, regWriteD}, 32'd0);
        checkVal("swImm", extImmD, 32'd8);
        checkVal("swMode", {29'd0, addressingModeD}, 32'd2);
        // addi x1,x0,-1
        instrD = 32'hFFF0_0093;
        #1;
        checkVal("negImm", extImmD, 32'hFFFF_FFFF);
        // bne x1,x2,-8
        instrD = 32'hFE20_9CE3;
        #1;
        checkVal("bneCtl", {28'd0, aluControlD}, 32'hB);
        checkVal("bneBranch", {31'd0, branchD}, 32'd1);
        checkVal("bneImm", extImmD, 32'hFFFF_FFF8);

        // Register file: write x3 = 0x1234 while reading it.
        @(negedge clk);
        instrD    = 32'h0031_8093;  // rs1 = x3
        regWriteW = 1'b1;
        rdW       = 5'd3;
        resultW   = 32'h1234;
        #1;
`ifdef REGFILE_BYPASS_EN
        checkVal("sameCycleRead", rd1D, 32'h1234);
`else
        checkVal("sameCycleRead", rd1D, 32'd0);
`endif
        tick();
        regWriteW = 1'b0;
        #1;
        checkVal("readX3", rd1D, 32'h1234);
        instrD = 32'h0030_0033;  // rs2 = x3
        #1;
        checkVal("readX3rs2", rd2D, 32'h1234);
        // Write x0 = 7 must be ignored.
        @(negedge clk);
        instrD    = 32'h0000_0093;
        regWriteW = 1'b1;
        rdW       = 5'd0;
        resultW   = 32'd7;
        #1;
        checkVal("x0DuringWrite", rd1D, 32'd0);
        tick();
        regWriteW = 1'b0;
        #1;
        checkVal("x0AfterWrite", rd1D, 32'd0);

        // Forwarding: first place 10 into aluResultM.
        @(negedge clk);
        aluControlE = 4'b0000;
        aluSrcE     = 1'b1;
        rd1E        = 32'd7;
        extImmE     = 32'd3;
        tick();
        checkVal("fwdSetupM", aluResultM, 32'd10);
        stallM  = 1'b1;
        rd1E    = 32'd1;
        resultW = 32'd20;
        forwardAE = 2'b00; #1; checkVal("fwdA00", aluResultE, 32'd4);
        forwardAE = 2'b10; #1; checkVal("fwdA10", aluResultE, 32'd13);
        forwardAE = 2'b01; #1; checkVal("fwdA01", aluResultE, 32'd23);
        forwardAE = 2'b11; #1; checkVal("fwdA11", aluResultE, 32'd4);
        forwardAE = 2'b00;
        aluSrcE   = 1'b0;
        rd2E      = 32'd99;
        forwardBE = 2'b10; #1; checkVal("fwdB10", writeDataE, 32'd10);
        forwardBE = 2'b01; #1; checkVal("fwdB01", writeDataE, 32'd20);
        forwardBE = 2'b00; #1; checkVal("fwdB00", writeDataE, 32'd99);
        stallM = 1'b0;

        // ALU sweep through register operands.
        for (int i = 0; i < 14; i++) begin
            aluControlE = aluVecs[i].op;
            rd1E        = aluVecs[i].a;
            rd2E        = aluVecs[i].b;
            #1;
            checkVal($sformatf("alu%0d", i), aluResultE, aluVecs[i].exp);
        end

        // Branch conditions and target.
        branchE = 1'b1;
        for (int i = 0; i < 6; i++) begin
            aluControlE = brVecs[i].op;
            rd1E        = brVecs[i].a;
            rd2E        = brVecs[i].b;
            #1;
            checkVal(brVecs[i].tag, {31'd0, branchTakenE}, {31'd0, brVecs[i].taken});
        end
        aluControlE = 4'b0001;
        rd1E        = 32'd7;
        rd2E        = 32'd7;
        branchE     = 1'b0;
        #1;
        checkVal("beqNoBranch", {31'd0, branchTakenE}, 32'd0);
        pcE     = 32'h100;
        extImmE = 32'hFFFF_FFF8;
        #1;
        checkVal("brTarget", branchTargetE, 32'hF8);

        // EX/MEM load.
        @(negedge clk);
        aluControlE     = 4'b1010;
        aluSrcE         = 1'b1;
        extImmE         = 32'hCAFE;
        rd2E            = 32'hBEEF;
        pcPlus4E        = 32'h104;
        rdE             = 5'd5;
        regWriteE       = 1'b1;
        memWriteE       = 1'b1;
        resultSrcE      = 2'b10;
        addressingModeE = 3'd3;
        tick();
        checkVal("loadAlu", aluResultM, 32'hCAFE);
        checkVal("loadWd", writeDataM, 32'hBEEF);
        checkVal("loadPc4", pcPlus4M, 32'h104);
        checkVal("loadRd", {27'd0, rdM}, 32'd5);
        checkVal("loadCtl", {24'd0, regWriteM, memWriteM, resultSrcM, 1'b0, addressingModeM},
                 32'b1110_0011);
        // Stall holds.
        stallM   = 1'b1;
        extImmE  = 32'h1111;
        rd2E     = 32'h2222;
        rdE      = 5'd9;
        tick();
        checkVal("stallAlu", aluResultM, 32'hCAFE);
        checkVal("stallRd", {27'd0, rdM}, 32'd5);
        // Flush beats stall.
        flushM = 1'b1;
        tick();
        checkVal("flushAlu", aluResultM, 32'd0);
        checkVal("flushWd", writeDataM, 32'd0);
        checkVal("flushCtl", {24'd0, regWriteM, memWriteM, resultSrcM, 1'b0, addressingModeM},
                 32'd0);
        flushM = 1'b0;
        stallM = 1'b0;
        tick();
        checkVal("reloadAlu", aluResultM, 32'h1111);

        // Asynchronous reset mid-cycle.
        instrD = 32'h0031_8093;  // rs1 = x3
        #3 rst = 1'b1;
        #1;
        checkVal("asyncRstAlu", aluResultM, 32'd0);
        checkVal("asyncRstRd", {27'd0, rdM}, 32'd0);
        checkVal("asyncRstX3", rd1D, 32'd0);
        #2 rst = 1'b0;

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
